dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl.sv | 154 +++++++++++++++
 tb/tb_dmem_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns a pipeline load/store into a single
// bus transaction, stalls the pipeline while it is outstanding, and aligns load data.
module dmem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] mem_data_out,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [1:0]    acc_size;
    logic [1:0]    acc_offset;
    logic          acc_unsigned;

    logic        align_ok;
    logic        legal;
    logic        accept;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] load_data;

    always_comb begin
        align_ok = 1'b0;
        case (size)
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~addr[0];
            2'b10:   align_ok = (addr[1:0] == 2'b00);
            default: align_ok = 1'b0;
        endcase
    end

    assign legal        = (mem_read ^ mem_write) & align_ok;
    assign accept       = (state == IDLE) & legal;
    assign misalign_exc = (state == IDLE) & (mem_read | mem_write) & ~legal;
    assign stall        = accept | (state == BUSY);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (size)
            2'b00: begin
                be_next    = 4'b0001 << addr[1:0];
                wdata_next = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    // Lane selection uses the offset captured at accept time, not the live address.
    always_comb begin
        load_data = bus_rdata;
        case (acc_size)
            2'b00: begin
                load_data[7:0]  = bus_rdata[{acc_offset, 3'b000} +: 8];
                load_data[31:8] = acc_unsigned ? 24'h0 : {24{load_data[7]}};
            end
            2'b01: begin
                load_data[15:0]  = bus_rdata[{acc_offset[1], 4'b0000} +: 16];
                load_data[31:16] = acc_unsigned ? 16'h0 : {16{load_data[15]}};
            end
            default: load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 32'h0;
            bus_be       <= 4'h0;
            bus_wdata    <= 32'h0;
            mem_data_out <= 32'h0;
            bus_err      <= 1'b0;
            acc_size     <= 2'b00;
            acc_offset   <= 2'b00;
            acc_unsigned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state        <= BUSY;
                        wait_cnt     <= '0;
                        bus_req      <= 1'b1;
                        bus_we       <= mem_write;
                        bus_addr     <= {addr[31:2], 2'b00};
                        bus_be       <= be_next;
                        bus_wdata    <= wdata_next;
                        bus_err      <= 1'b0;
                        acc_size     <= size;
                        acc_offset   <= addr[1:0];
                        acc_unsigned <= load_unsigned;
                    end
                end
                BUSY: begin
                    // An ack in the final wait cycle takes priority over the timeout.
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            mem_data_out <= load_data;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state        <= DONE;
                        bus_req      <= 1'b0;
                        mem_data_out <= 32'h0;
                        bus_err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with TIMEOUT = 4: loads, stores, alignment
// exceptions, bus timeout and asynchronous reset during a transaction.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        load_unsigned;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [31:0] mem_data_out;
    logic        misalign_exc;
    logic        bus_err;

    int errors = 0;
    int checks = 0;

    int          stall_n;
    int          req_n;
    logic        first_exc;
    logic        stable_ok;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wd;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .wdata        (wdata),
        .size         (size),
        .load_unsigned(load_unsigned),
        .stall        (stall),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .mem_data_out (mem_data_out),
        .misalign_exc (misalign_exc),
        .bus_err      (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Presents one request and runs until DONE (legal) or returns at once (illegal).
    // ack_cyc selects the BUSY cycle (1-based) on which bus_ack is driven; 0 = never.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic lu,
                          input int ack_cyc, input logic [31:0] rdat);
        bit fin;
        stall_n   = 0;
        req_n     = 0;
        stable_ok = 1'b1;
        fin       = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        size      = sz;
        load_unsigned = lu;
        bus_rdata = rdat;
        #1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c == 0) first_exc = misalign_exc;
            if (bus_req) begin
                req_n++;
                if (req_n == 1) begin
                    obs_we = bus_we; obs_addr = bus_addr; obs_be = bus_be; obs_wd = bus_wdata;
                end else if (obs_we !== bus_we || obs_addr !== bus_addr ||
                             obs_be !== bus_be || obs_wd !== bus_wdata) begin
                    stable_ok = 1'b0;
                end
            end
            if (stall) stall_n++;
            if (!stall && !bus_req) begin
                fin = 1'b1;
            end else begin
                bus_ack = bus_req && (req_n == ack_cyc);
                @(posedge clk);
                #1;
                bus_ack = 1'b0;
            end
        end
        if (!fin) check("access_bound", 32'd0, 32'd1);
    endtask

    task automatic release_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;
        size = 2'b10; load_unsigned = 1'b0; bus_rdata = 32'h0; bus_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_bus_req", {31'h0, bus_req}, 32'd0);
        check("rst_stall", {31'h0, stall}, 32'd0);
        check("rst_data", mem_data_out, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'd0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_be", {28'h0, bus_be}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word load, immediate ack
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'hDEADBEEF);
        check("wl_stall_cycles", stall_n, 2);
        check("wl_req_cycles", req_n, 1);
        check("wl_addr", obs_addr, 32'h100);
        check("wl_be", {28'h0, obs_be}, 32'hF);
        check("wl_we", {31'h0, obs_we}, 32'd0);
        check("wl_data", mem_data_out, 32'hDEADBEEF);
        check("wl_done_stall", {31'h0, stall}, 32'd0);
        release_req();

        // Signed and unsigned byte loads from the top lane
        access(1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b0, 1, 32'h80FF1234);
        check("lb_be", {28'h0, obs_be}, 32'h8);
        check("lb_addr", obs_addr, 32'h200);
        check("lb_data", mem_data_out, 32'hFFFFFF80);
        release_req();
        access(1'b1, 1'b0, 32'h203, 32'h0, 2'b00, 1'b1, 1, 32'h80FF1234);
        check("lbu_data", mem_data_out, 32'h00000080);
        release_req();

        // Half store, upper half
        access(1'b0, 1'b1, 32'h302, 32'h0000ABCD, 2'b01, 1'b0, 1, 32'h11111111);
        check("sh_be", {28'h0, obs_be}, 32'hC);
        check("sh_wdata", obs_wd, 32'hABCDABCD);
        check("sh_we", {31'h0, obs_we}, 32'd1);
        check("sh_addr", obs_addr, 32'h300);
        check("sh_data_kept", mem_data_out, 32'h00000080);
        release_req();

        // Byte store, lane 1
        access(1'b0, 1'b1, 32'h201, 32'h1234565A, 2'b00, 1'b0, 1, 32'h0);
        check("sb_be", {28'h0, obs_be}, 32'h2);
        check("sb_wdata", obs_wd, 32'h5A5A5A5A);
        release_req();

        // Signed half load with three wait states
        access(1'b1, 1'b0, 32'h206, 32'h0, 2'b01, 1'b0, 3, 32'hC0DE1111);
        check("lh_stall_cycles", stall_n, 4);
        check("lh_req_cycles", req_n, 3);
        check("lh_stable", {31'h0, stable_ok}, 32'd1);
        check("lh_be", {28'h0, obs_be}, 32'hC);
        check("lh_data", mem_data_out, 32'hFFFFC0DE);
        release_req();

        // Illegal requests
        access(1'b1, 1'b0, 32'h101, 32'h0, 2'b10, 1'b0, 1, 32'h0);
        check("mis_exc", {31'h0, first_exc}, 32'd1);
        check("mis_stall", stall_n, 0);
        check("mis_req", req_n, 0);
        check("mis_data_kept", mem_data_out, 32'hFFFFC0DE);
        release_req();
        access(1'b1, 1'b1, 32'h100, 32'h0, 2'b10, 1'b0, 1, 32'h0);
        check("rw_exc", {31'h0, first_exc}, 32'd1);
        check("rw_req", req_n, 0);
        release_req();
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'b11, 1'b0, 1, 32'h0);
        check("sz11_exc", {31'h0, first_exc}, 32'd1);
        release_req();
        check("idle_no_exc", {31'h0, misalign_exc}, 32'd0);

        // Timeout with no ack
        access(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 0, 32'h55555555);
        check("to_req_cycles", req_n, 4);
        check("to_stall_cycles", stall_n, 5);
        check("to_bus_err", {31'h0, bus_err}, 32'd1);
        check("to_data", mem_data_out, 32'h0);
        release_req();
        check("to_err_held", {31'h0, bus_err}, 32'd1);

        // Ack on the final allowed cycle wins
        access(1'b1, 1'b0, 32'h404, 32'h0, 2'b10, 1'b0, 4, 32'h0BADF00D);
        check("late_req_cycles", req_n, 4);
        check("late_bus_err", {31'h0, bus_err}, 32'd0);
        check("late_data", mem_data_out, 32'h0BADF00D);
        release_req();

        // Asynchronous reset in the middle of a wait
        mem_read = 1'b1; addr = 32'h500; size = 2'b10; load_unsigned = 1'b0;
        @(posedge clk);
        #1;
        check("ar_busy_req", {31'h0, bus_req}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("ar_req_dropped", {31'h0, bus_req}, 32'd0);
        check("ar_data_cleared", mem_data_out, 32'h0);
        mem_read = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        bus_rdata = 32'h12345678;
        bus_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        check("ar_ack_ignored_req", {31'h0, bus_req}, 32'd0);
        check("ar_ack_ignored_data", mem_data_out, 32'h0);
        check("ar_ack_ignored_stall", {31'h0, stall}, 32'd0);
        access(1'b1, 1'b0, 32'h600, 32'h0, 2'b10, 1'b0, 1, 32'hCAFEF00D);
        check("ar_resume_stall", stall_n, 2);
        check("ar_resume_data", mem_data_out, 32'hCAFEF00D);
        release_req();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
